decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register, PC and immediate values.
REQ-002 Parameter AW, default 5, register address width; register file holds 2**AW entries.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 InstrD  input  32  instruction in decode.
REQ-006 PCD, PCPlus4D  input  XLEN each  PC and PC+4 of InstrD.
REQ-007 ValidD  input  1  InstrD is a real instruction.
REQ-008 RegWriteW  input  1  writeback enable.
REQ-009 RDW  input  AW  writeback address.
REQ-010 ResultW  input  XLEN  writeback data.
REQ-011 FlushE  input  1  kill the instruction entering E (taken branch/jump).
REQ-012 HoldE  input  1  freeze the E register (downstream stall).
REQ-013 CtrlE  output  CTRL_W  packed control: RegWrite, ALUSrc, MemWrite, ResultSrc[1:0], Branch, Jump, ALUControl[2:0].
REQ-014 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  output  XLEN each  registered operands, immediate and PCs.
REQ-015 RD_E, RS1_E, RS2_E  output  AW each  registered destination and source addresses.
REQ-016 ValidE  output  1  E register holds a real instruction.
REQ-017 HazardStallD  output  1  load-use hazard; fetch and F/D register must hold.

Function
REQ-018 Decode SHALL be combinational from InstrD: lw, sw, R-type ALU, I-type ALU, beq, jal and lui SHALL be supported; any other opcode SHALL give all-zero control.
REQ-019 Immediates SHALL be formed for I, S, B, U and J formats and sign-extended (U: zero-filled low 12 bits) to XLEN.
REQ-020 ALUControl SHALL be add=000, sub=001, and=010, or=011, slt=101; lw, sw and jal SHALL use add; beq SHALL use sub.
REQ-021 E-register update SHALL have priority rst > HoldE > (FlushE or HazardStallD) > load.
REQ-022 On load, every E field SHALL capture its decode value one cycle later, with ValidE=ValidD.
REQ-023 On HoldE, every E field SHALL keep its value.
REQ-024 On a bubble (FlushE or HazardStallD without HoldE), every E output SHALL become zero, including ValidE and CtrlE.
REQ-025 HazardStallD SHALL be combinational: ValidE && ResultSrcE==01 (load) && RD_E!=0 && ValidD && (RD_E==InstrD[19:15] || RD_E==InstrD[24:20]); HoldE SHALL NOT mask it.
REQ-026 Register reads SHALL be asynchronous; entry 0 SHALL always read zero.
REQ-027 A write SHALL occur on the clock edge when RegWriteW && RDW!=0.
REQ-028 A same-cycle read of RDW SHALL return ResultW (write-through bypass); no bypass SHALL occur for RDW==0.
REQ-029 Simultaneous write and HoldE: the register file SHALL be written, and held RD1_E/RD2_E SHALL NOT be refreshed.

Reset
REQ-030 While rst is high at a clock edge, every E output and ValidE SHALL become zero.
REQ-031 While rst is high at a clock edge, all register-file entries SHALL become zero.
REQ-032 A reset asserted mid-operation SHALL override HoldE, FlushE and pending hazards; HazardStallD SHALL be 0 in the cycle after reset.

Structure
REQ-033 Shared package decode_pkg SHALL hold: opcode constants, the ImmSrc enum (I,S,B,U,J), the ALUControl encodings, the ResultSrc encodings (00 ALU, 01 mem, 10 PC+4), CTRL_W and the CtrlE field positions.
REQ-034 One sub-module, decode_regfile (parameters XLEN and AW; 2 read ports, 1 write port, bypass, sync reset), SHALL be instantiated.
REQ-035 Control decode, immediate generation and hazard logic SHALL be inline.

Verification
REQ-036 Reset: hold rst 2 cycles with ValidD=1 -> all E outputs 0; rf read x5=0.
REQ-037 Write-through: RegWriteW=1, RDW=7, ResultW=0xDEADBEEF, InstrD=add x1,x7,x0 -> next cycle RD1_E=0xDEADBEEF; RDW=0, ResultW=0x55 -> reads of x0 give 0.
REQ-038 Load-use: lw x3,0(x2) enters E, then InstrD=add x4,x3,x1 -> HazardStallD=1 one cycle, E gets bubble (ValidE=0, CtrlE=0); add enters E the following cycle.
REQ-039 Flush: FlushE=1 with InstrD=sw -> next cycle ValidE=0, MemWrite=0.
REQ-040 Hold priority: HoldE=1 and FlushE=1 for 3 cycles with a beq in E -> E unchanged (PCE and CtrlE constant); releasing HoldE with FlushE=1 -> bubble.
REQ-041 Immediates: jal with offset -4 -> Imm_Ext_E=0xFFFFFFFC; lui 0x12345 -> 0x12345000; unknown opcode 0x7F -> CtrlE=0 with ValidE=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats, ALU and result-select encodings, control layout.
package decode_pkg;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immSrc_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Bit positions of the fields inside CtrlE, MSB first.
   localparam int CTRL_W          = 10;
   localparam int CTRL_REGWRITE   = 9;
   localparam int CTRL_ALUSRC     = 8;
   localparam int CTRL_MEMWRITE   = 7;
   localparam int CTRL_RES_HI     = 6;
   localparam int CTRL_RES_LO     = 5;
   localparam int CTRL_BRANCH     = 4;
   localparam int CTRL_JUMP       = 3;
   localparam int CTRL_ALU_HI     = 2;
   localparam int CTRL_ALU_LO     = 0;

   typedef struct packed {
      logic       regWrite;
      logic       aluSrc;
      logic       memWrite;
      logic [1:0] resultSrc;
      logic       branch;
      logic       jump;
      logic [2:0] aluControl;
   } ctrl_t;

   // ALU operation for register and immediate arithmetic; sub only exists in R-type.
   function automatic logic [2:0] aluDecode(input logic [2:0] funct3, input logic isSub);
      case (funct3)
         3'b000:  aluDecode = isSub ? ALU_SUB : ALU_ADD;
         3'b010:  aluDecode = ALU_SLT;
         3'b110:  aluDecode = ALU_OR;
         3'b111:  aluDecode = ALU_AND;
         default: aluDecode = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// 2-read/1-write register file, x0 hardwired to zero, same-cycle write-through to both read ports.
// Reads are combinational; writes land on the clock edge; no backpressure.
module decode_regfile #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = mem[ra1];
      rd2 = mem[ra2];
      if (we && wa != '0 && wa == ra1) rd1 = wd;
      if (we && wa != '0 && wa == ra2) rd2 = wd;
      if (ra1 == '0) rd1 = '0;
      if (ra2 == '0) rd2 = '0;
   end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: control decode, immediates, register read and the D->E register (1 cycle).
// HoldE freezes E; a load-use hazard raises HazardStallD and inserts a bubble into E.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              ValidD,
   input  logic              RegWriteW,
   input  logic [AW-1:0]     RDW,
   input  logic [XLEN-1:0]   ResultW,
   input  logic              FlushE,
   input  logic              HoldE,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [XLEN-1:0]   RD1_E,
   output logic [XLEN-1:0]   RD2_E,
   output logic [XLEN-1:0]   Imm_Ext_E,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic [AW-1:0]     RD_E,
   output logic [AW-1:0]     RS1_E,
   output logic [AW-1:0]     RS2_E,
   output logic              ValidE,
   output logic              HazardStallD
);
   ctrl_t           ctrlD;
   immSrc_e         immSrc;
   logic [31:0]     imm32;
   logic [XLEN-1:0] immD, rd1D, rd2D;
   logic [AW-1:0]   rs1D, rs2D, rdD;
   logic [6:0]      opcode;
   logic [2:0]      funct3;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign rs1D   = AW'(InstrD[19:15]);
   assign rs2D   = AW'(InstrD[24:20]);
   assign rdD    = AW'(InstrD[11:7]);

   always_comb begin
      ctrlD  = '0;
      immSrc = IMM_I;
      case (opcode)
         OP_LW:  begin
            ctrlD.regWrite  = 1'b1;
            ctrlD.aluSrc    = 1'b1;
            ctrlD.resultSrc = RES_MEM;
         end
         OP_SW:  begin
            ctrlD.aluSrc   = 1'b1;
            ctrlD.memWrite = 1'b1;
            immSrc         = IMM_S;
         end
         OP_R:   begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluControl = aluDecode(funct3, InstrD[30]);
         end
         OP_I:   begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.aluControl = aluDecode(funct3, 1'b0);
         end
         OP_BEQ: begin
            ctrlD.branch     = 1'b1;
            ctrlD.aluControl = ALU_SUB;
            immSrc           = IMM_B;
         end
         OP_JAL: begin
            ctrlD.regWrite  = 1'b1;
            ctrlD.resultSrc = RES_PC4;
            ctrlD.jump      = 1'b1;
            immSrc          = IMM_J;
         end
         OP_LUI: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluSrc   = 1'b1;
            immSrc         = IMM_U;
         end
         default: ctrlD = '0;
      endcase
   end

   always_comb begin
      case (immSrc)
         IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_U:   imm32 = {InstrD[31:12], 12'b0};
         IMM_J:   imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      endcase
      immD = XLEN'($signed(imm32));
   end

   decode_regfile #(.XLEN(XLEN), .AW(AW)) uRegfile (
      .clk (clk),
      .rst (rst),
      .we  (RegWriteW),
      .wa  (RDW),
      .wd  (ResultW),
      .ra1 (rs1D),
      .ra2 (rs2D),
      .rd1 (rd1D),
      .rd2 (rd2D)
   );

   // Deliberately not gated by HoldE: fetch must stall even while E is frozen.
   assign HazardStallD = ValidE && (CtrlE[CTRL_RES_HI:CTRL_RES_LO] == RES_MEM) && (RD_E != '0)
                         && ValidD && (RD_E == rs1D || RD_E == rs2D);

   always_ff @(posedge clk) begin
      if (rst || (!HoldE && (FlushE || HazardStallD))) begin
         CtrlE     <= '0;
         RD1_E     <= '0;
         RD2_E     <= '0;
         Imm_Ext_E <= '0;
         PCE       <= '0;
         PCPlus4E  <= '0;
         RD_E      <= '0;
         RS1_E     <= '0;
         RS2_E     <= '0;
         ValidE    <= 1'b0;
      end else if (!HoldE) begin
         CtrlE     <= ctrlD;
         RD1_E     <= rd1D;
         RD2_E     <= rd2D;
         Imm_Ext_E <= immD;
         PCE       <= PCD;
         PCPlus4E  <= PCPlus4D;
         RD_E      <= rdD;
         RS1_E     <= rs1D;
         RS2_E     <= rs2D;
         ValidE    <= ValidD;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each issued cycle queues the expected E contents,
// a monitor pops one entry per clock and compares; HazardStallD is checked before each edge.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst, ValidD, RegWriteW, FlushE, HoldE;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic [4:0]  RDW;
   logic [9:0]  CtrlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RD_E, RS1_E, RS2_E;
   logic        ValidE, HazardStallD;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .AW(5)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
      .CtrlE(CtrlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .ValidE(ValidE),
      .HazardStallD(HazardStallD)
   );

   // Hand-assembled instructions
   localparam logic [31:0] ADD8_5_0   = 32'h00028433; // add x8,x5,x0
   localparam logic [31:0] ADD1_7_0   = 32'h000380B3; // add x1,x7,x0
   localparam logic [31:0] ADD9_0_0   = 32'h000004B3; // add x9,x0,x0
   localparam logic [31:0] ADD10_7_2  = 32'h00238533; // add x10,x7,x2
   localparam logic [31:0] LW3_2      = 32'h00012183; // lw x3,0(x2)
   localparam logic [31:0] ADD4_3_1   = 32'h00118233; // add x4,x3,x1
   localparam logic [31:0] SW5_8_2    = 32'h00512423; // sw x5,8(x2)
   localparam logic [31:0] BEQ1_2_16  = 32'h00208863; // beq x1,x2,16
   localparam logic [31:0] ADD11_2_0  = 32'h000105B3; // add x11,x2,x0
   localparam logic [31:0] JAL1_M4    = 32'hFFDFF0EF; // jal x1,-4
   localparam logic [31:0] LUI5       = 32'h123452B7; // lui x5,0x12345
   localparam logic [31:0] UNKNOWN    = 32'h0000007F;
   localparam logic [31:0] ADDI6_M1   = 32'hFFF00313; // addi x6,x0,-1

   typedef struct {
      int          id;
      bit          cVal, cOps, cImm, cPc, cAddr;
      logic [9:0]  ctrl;
      logic        valid;
      logic [31:0] rd1, rd2, imm, pce, pcp4;
      logic [4:0]  rd, rs1, rs2;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   passes = 0;
   int   cycNo  = 0;

   task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
   endtask

   function automatic exp_t bub();
      exp_t e;
      e = '{id: 0, cVal: 1, cOps: 1, cImm: 1, cPc: 1, cAddr: 1, ctrl: '0, valid: 1'b0,
            rd1: '0, rd2: '0, imm: '0, pce: '0, pcp4: '0, rd: '0, rs1: '0, rs2: '0};
      return e;
   endfunction

   function automatic exp_t ld(input logic [9:0] c, input logic v, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      exp_t e;
      e = '{id: 0, cVal: 1, cOps: 1, cImm: 0, cPc: 1, cAddr: 1, ctrl: c, valid: v,
            rd1: r1, rd2: r2, imm: '0, pce: pc, pcp4: pc + 32'd4, rd: rd, rs1: rs1, rs2: rs2};
      return e;
   endfunction

   // Expected E for an immediate-focused vector: only control, validity, PCs and immediate matter.
   function automatic exp_t immE(input logic [9:0] c, input logic [31:0] pc, input logic [31:0] imm);
      exp_t e;
      e = ld(c, 1'b1, '0, '0, pc, '0, '0, '0);
      e.cOps  = 0;
      e.cAddr = 0;
      e.cImm  = 1;
      e.imm   = imm;
      return e;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; ValidD = 1'b1; rst = 1'b0;
      RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0; HoldE = 1'b0;
   endtask

   task automatic haz(input logic exp);
      #1;
      cmp("hazard", cycNo, 32'(HazardStallD), 32'(exp));
   endtask

   task automatic cyc(input exp_t e);
      e.id = cycNo;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      cycNo++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (sbQ.size() != 0) begin
            exp_t e;
            e = sbQ.pop_front();
            if (e.cVal) begin
               cmp("ValidE", e.id, 32'(ValidE), 32'(e.valid));
               cmp("CtrlE", e.id, 32'(CtrlE), 32'(e.ctrl));
            end
            if (e.cOps) begin
               cmp("RD1_E", e.id, RD1_E, e.rd1);
               cmp("RD2_E", e.id, RD2_E, e.rd2);
            end
            if (e.cImm) cmp("Imm_Ext_E", e.id, Imm_Ext_E, e.imm);
            if (e.cPc) begin
               cmp("PCE", e.id, PCE, e.pce);
               cmp("PCPlus4E", e.id, PCPlus4E, e.pcp4);
            end
            if (e.cAddr) begin
               cmp("RD_E", e.id, 32'(RD_E), 32'(e.rd));
               cmp("RS1_E", e.id, 32'(RS1_E), 32'(e.rs1));
               cmp("RS2_E", e.id, 32'(RS2_E), 32'(e.rs2));
            end
         end
      end
   end

   initial begin
      exp_t e;
      // Reset held two cycles with a live instruction at the input
      drive(LW3_2, 32'h80); rst = 1'b1; cyc(bub());
      drive(LW3_2, 32'h80); rst = 1'b1; cyc(bub());
      // x5 reads zero after reset
      drive(ADD8_5_0, 32'h100); haz(1'b0); cyc(ld(10'h200, 1, 0, 0, 32'h100, 8, 5, 0));
      // Write-through bypass on rs1
      drive(ADD1_7_0, 32'h104); RegWriteW = 1; RDW = 7; ResultW = 32'hDEADBEEF;
      cyc(ld(10'h200, 1, 32'hDEADBEEF, 0, 32'h104, 1, 7, 0));
      // Write to x0 is neither stored nor bypassed
      drive(ADD9_0_0, 32'h108); RegWriteW = 1; RDW = 0; ResultW = 32'h55;
      cyc(ld(10'h200, 1, 0, 0, 32'h108, 9, 0, 0));
      // x7 stored; x2 bypassed on rs2
      drive(ADD10_7_2, 32'h10C); RegWriteW = 1; RDW = 2; ResultW = 32'h1000;
      cyc(ld(10'h200, 1, 32'hDEADBEEF, 32'h1000, 32'h10C, 10, 7, 2));
      // Load-use sequence
      drive(LW3_2, 32'h110); haz(1'b0);
      e = ld(10'h320, 1, 32'h1000, 0, 32'h110, 3, 2, 0); e.cImm = 1; e.imm = 0; cyc(e);
      drive(ADD4_3_1, 32'h114); haz(1'b1); cyc(bub());
      drive(ADD4_3_1, 32'h114); haz(1'b0); cyc(ld(10'h200, 1, 0, 0, 32'h114, 4, 3, 1));
      // Flush kills a store
      drive(SW5_8_2, 32'h118); FlushE = 1; haz(1'b0); cyc(bub());
      // beq enters E, then HoldE+FlushE freeze it while x2 is rewritten
      drive(BEQ1_2_16, 32'h200);
      e = ld(10'h011, 1, 0, 32'h1000, 32'h200, 16, 1, 2); e.cImm = 1; e.imm = 32'd16; cyc(e);
      for (int i = 0; i < 3; i++) begin
         drive(JAL1_M4, 32'h300); HoldE = 1; FlushE = 1;
         if (i == 0) begin RegWriteW = 1; RDW = 2; ResultW = 32'h2222; end
         cyc(e);
      end
      drive(JAL1_M4, 32'h300); FlushE = 1; cyc(bub());
      // x2 was written during the hold
      drive(ADD11_2_0, 32'h304); cyc(ld(10'h200, 1, 32'h2222, 0, 32'h304, 11, 2, 0));
      // Immediate formats and unknown opcode
      drive(JAL1_M4, 32'h400);  cyc(immE(10'h248, 32'h400, 32'hFFFFFFFC));
      drive(LUI5, 32'h404);     cyc(immE(10'h300, 32'h404, 32'h12345000));
      drive(UNKNOWN, 32'h408);  e = immE(10'h000, 32'h408, 0); e.cImm = 0; cyc(e);
      drive(ADDI6_M1, 32'h40C); cyc(immE(10'h300, 32'h40C, 32'hFFFFFFFF));
      // Non-valid instruction loads with ValidE low
      drive(ADD8_5_0, 32'h410); ValidD = 0; cyc(ld(10'h200, 0, 0, 0, 32'h410, 8, 5, 0));
      // Reset in the middle of a pending load-use with HoldE asserted
      drive(LW3_2, 32'h500); haz(1'b0); cyc(ld(10'h320, 1, 32'h2222, 0, 32'h500, 3, 2, 0));
      drive(ADD4_3_1, 32'h504); rst = 1; HoldE = 1; haz(1'b1); cyc(bub());
      drive(ADD4_3_1, 32'h504); haz(1'b0); cyc(ld(10'h200, 1, 0, 0, 32'h504, 4, 3, 1));
      // Register file cleared by that reset
      drive(ADD11_2_0, 32'h508); haz(1'b0); cyc(ld(10'h200, 1, 0, 0, 32'h508, 11, 2, 0));

      for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge clk);
      #5;
      if (sbQ.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected entries left, required 0", sbQ.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
